// File: rtl/adc_pulse_pattern_gen_pkg.sv
// Shared lane layout, saturating arithmetic and FSM states for trigger-chain stimulus blocks.
package adc_pulse_pattern_gen_pkg;

    localparam int LaneW = 16;

    typedef enum logic [2:0] {StIdle, StPre, StFst, StSnd, StGap} state_e;

    // Sample (sign-extended to a lane) is MSB-aligned; low lane bits are zero.
    function automatic logic [LaneW-1:0] pack_lane(input logic signed [LaneW-1:0] s,
                                                   input int res);
        return s << (LaneW - res);
    endfunction

    function automatic logic signed [LaneW-1:0] sat_add(input logic signed [LaneW-1:0] a,
                                                        input logic signed [LaneW-1:0] b,
                                                        input int res);
        logic signed [LaneW:0] sum;
        logic signed [LaneW:0] hi;
        logic signed [LaneW:0] lo;
        sum = {a[LaneW-1], a} + {b[LaneW-1], b};
        hi  = (LaneW+1)'((1 <<< (res - 1)) - 1);
        lo  = (LaneW+1)'(-(1 <<< (res - 1)));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[LaneW-1:0];
    endfunction

endpackage

// File: rtl/adc_word_packer.sv
// Builds one TDATA word: either a flat peak on every lane or +/-1 noise around a baseline.
module adc_word_packer
    import adc_pulse_pattern_gen_pkg::*;
#(
    parameter int TDATA_WIDTH          = 128,
    parameter int ADC_RESOLUTION_WIDTH = 12
) (
    input  logic                                   peak_i,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0] peak_val_i,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0] baseline_i,
    output logic        [TDATA_WIDTH-1:0]          tdata_o
);

    localparam int SamplesPerTdata = TDATA_WIDTH / LaneW;

    logic signed [LaneW-1:0] base_ext;
    logic signed [LaneW-1:0] peak_ext;
    logic        [LaneW-1:0] even_lane;
    logic        [LaneW-1:0] odd_lane;
    logic        [LaneW-1:0] peak_lane;

    always_comb begin
        base_ext  = LaneW'(baseline_i);
        peak_ext  = LaneW'(peak_val_i);
        even_lane = pack_lane(sat_add(base_ext, -16'sd1, ADC_RESOLUTION_WIDTH),
                              ADC_RESOLUTION_WIDTH);
        odd_lane  = pack_lane(sat_add(base_ext, 16'sd1, ADC_RESOLUTION_WIDTH),
                              ADC_RESOLUTION_WIDTH);
        peak_lane = pack_lane(peak_ext, ADC_RESOLUTION_WIDTH);
    end

    always_comb begin
        tdata_o = '0;
        for (int k = 0; k < SamplesPerTdata; k++) begin
            if (peak_i) begin
                tdata_o[k*LaneW +: LaneW] = peak_lane;
            end else if (k % 2 == 0) begin
                tdata_o[k*LaneW +: LaneW] = even_lane;
            end else begin
                tdata_o[k*LaneW +: LaneW] = odd_lane;
            end
        end
    end

endmodule

// File: rtl/adc_pulse_pattern_gen.sv
// Free-running AXI-Stream ADC model: baseline noise plus a finite train of double-peak pulses.
module adc_pulse_pattern_gen
    import adc_pulse_pattern_gen_pkg::*;
#(
    parameter int TDATA_WIDTH          = 128,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int LEN_WIDTH            = 16
) (
    input  logic                                   M_AXIS_ACLK,
    input  logic                                   M_AXIS_ARESETN,
    output logic        [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
    output logic                                   M_AXIS_TVALID,
    input  logic                                   M_AXIS_TREADY,
    input  logic                                   START,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    input  logic        [LEN_WIDTH-1:0]            PRE_LEN,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0] FST_HEIGHT,
    input  logic        [LEN_WIDTH-1:0]            FST_WIDTH,
    input  logic signed [ADC_RESOLUTION_WIDTH-1:0] SND_HEIGHT,
    input  logic        [LEN_WIDTH-1:0]            SND_WIDTH,
    input  logic        [LEN_WIDTH-1:0]            GAP_LEN,
    input  logic        [LEN_WIDTH-1:0]            PULSE_COUNT,
    output logic                                   BUSY,
    output logic                                   DONE
);

    typedef logic [LEN_WIDTH-1:0] len_t;

    typedef struct packed {
        logic signed [ADC_RESOLUTION_WIDTH-1:0] base;
        logic signed [ADC_RESOLUTION_WIDTH-1:0] fst_h;
        logic signed [ADC_RESOLUTION_WIDTH-1:0] snd_h;
        len_t                                   pre;
        len_t                                   fst_w;
        len_t                                   snd_w;
        len_t                                   gap;
    } cfg_t;

    typedef struct packed {
        state_e st;
        len_t   cnt;
        len_t   rem;
        logic   fin;
    } nxt_t;

    // Successor resolution: zero-length phases are skipped within the same transition.
    function automatic nxt_t after_snd(input cfg_t c, input len_t rem);
        nxt_t n;
        n     = '0;
        n.rem = rem - len_t'(1);
        if (n.rem == '0) begin
            n.fin = 1'b1;
        end else if (c.gap != '0) begin
            n.st = StGap; n.cnt = c.gap;
        end else if (c.fst_w != '0) begin
            n.st = StFst; n.cnt = c.fst_w;
        end else if (c.snd_w != '0) begin
            n.st = StSnd; n.cnt = c.snd_w;
        end else begin
            n.rem = '0; n.fin = 1'b1;
        end
        return n;
    endfunction

    function automatic nxt_t after_fst(input cfg_t c, input len_t rem);
        nxt_t n;
        n = '0;
        if (c.snd_w != '0) begin
            n.st = StSnd; n.cnt = c.snd_w; n.rem = rem;
        end else begin
            n = after_snd(c, rem);
        end
        return n;
    endfunction

    function automatic nxt_t enter_fst(input cfg_t c, input len_t rem);
        nxt_t n;
        n = '0;
        if (c.fst_w != '0) begin
            n.st = StFst; n.cnt = c.fst_w; n.rem = rem;
        end else begin
            n = after_fst(c, rem);
        end
        return n;
    endfunction

    function automatic nxt_t enter_pre(input cfg_t c, input len_t rem);
        nxt_t n;
        n = '0;
        if (c.pre != '0) begin
            n.st = StPre; n.cnt = c.pre; n.rem = rem;
        end else begin
            n = enter_fst(c, rem);
        end
        return n;
    endfunction

    state_e state_q, state_d;
    len_t   cnt_q, cnt_d;
    len_t   rem_q, rem_d;
    cfg_t   cfg_q, cfg_d, cfg_in;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   tvalid_q;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d, word;

    logic   beat, start_acc, adv, peak_sel;
    nxt_t   nxt;
    logic signed [ADC_RESOLUTION_WIDTH-1:0] peak_val, noise_base;

    assign cfg_in = '{base: BASELINE, fst_h: FST_HEIGHT, snd_h: SND_HEIGHT, pre: PRE_LEN,
                      fst_w: FST_WIDTH, snd_w: SND_WIDTH, gap: GAP_LEN};

    assign beat      = tvalid_q & M_AXIS_TREADY;
    assign start_acc = START & (state_q == StIdle) & ~busy_q;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            cfg_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            cfg_q    <= cfg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= 1'b1;
            tdata_q  <= tdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        cfg_d   = cfg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        adv     = 1'b0;
        nxt     = '0;
        if (start_acc) begin
            cfg_d  = cfg_in;
            rem_d  = PULSE_COUNT;
            busy_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                // An armed train leaves IDLE on the beat that consumes the pending noise word.
                if (busy_q && rem_q == '0) begin
                    adv     = 1'b1;
                    nxt.fin = 1'b1;
                end else if (busy_d && rem_d != '0 && beat) begin
                    adv = 1'b1;
                    nxt = enter_pre(cfg_d, rem_d);
                end
            end
            StPre, StFst, StSnd, StGap: begin
                if (beat) begin
                    if (cnt_q != len_t'(1)) begin
                        cnt_d = cnt_q - len_t'(1);
                    end else begin
                        adv = 1'b1;
                        unique case (state_q)
                            StFst:   nxt = after_fst(cfg_q, rem_q);
                            StSnd:   nxt = after_snd(cfg_q, rem_q);
                            default: nxt = enter_fst(cfg_q, rem_q);
                        endcase
                    end
                end
            end
            default: ;
        endcase
        if (adv) begin
            state_d = nxt.st;
            cnt_d   = nxt.cnt;
            rem_d   = nxt.rem;
            if (nxt.fin) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign peak_sel   = (state_d == StFst) || (state_d == StSnd);
    assign peak_val   = (state_d == StFst) ? cfg_d.fst_h : cfg_d.snd_h;
    assign noise_base = busy_d ? cfg_d.base : BASELINE;

    adc_word_packer #(
        .TDATA_WIDTH          (TDATA_WIDTH),
        .ADC_RESOLUTION_WIDTH (ADC_RESOLUTION_WIDTH)
    ) u_packer (
        .peak_i     (peak_sel),
        .peak_val_i (peak_val),
        .baseline_i (noise_base),
        .tdata_o    (word)
    );

    always_comb begin
        tdata_d       = (!tvalid_q || beat) ? word : tdata_q;
        M_AXIS_TDATA  = tdata_q;
        M_AXIS_TVALID = tvalid_q;
        BUSY          = busy_q;
        DONE          = done_q;
    end

endmodule

// File: tb/tb_adc_pulse_pattern_gen.sv
// Scoreboard bench: expected beats are queued at START and popped on every observed beat.
module tb_adc_pulse_pattern_gen;

    localparam int TW  = 128;
    localparam int ARW = 12;
    localparam int LW  = 16;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [TW-1:0]         tdata;
    logic                  tvalid;
    logic                  tready = 1'b1;
    logic                  start = 1'b0;
    logic signed [ARW-1:0] baseline = '0;
    logic [LW-1:0]         pre_len = '0;
    logic signed [ARW-1:0] fst_h = '0;
    logic [LW-1:0]         fst_w = '0;
    logic signed [ARW-1:0] snd_h = '0;
    logic [LW-1:0]         snd_w = '0;
    logic [LW-1:0]         gap_len = '0;
    logic [LW-1:0]         pcount = '0;
    logic                  busy;
    logic                  done;

    always #5 clk = ~clk;

    adc_pulse_pattern_gen #(
        .TDATA_WIDTH          (TW),
        .ADC_RESOLUTION_WIDTH (ARW),
        .LEN_WIDTH            (LW)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rstn),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TREADY  (tready),
        .START          (start),
        .BASELINE       (baseline),
        .PRE_LEN        (pre_len),
        .FST_HEIGHT     (fst_h),
        .FST_WIDTH      (fst_w),
        .SND_HEIGHT     (snd_h),
        .SND_WIDTH      (snd_w),
        .GAP_LEN        (gap_len),
        .PULSE_COUNT    (pcount),
        .BUSY           (busy),
        .DONE           (done)
    );

    typedef struct {
        int base; int pre; int fh; int fw; int sh; int sw; int gap; int cnt;
    } tcfg_t;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_beat_cyc = 0;
    int            done_cnt = 0;
    int            base_now = 0;
    bit            capture = 1'b0;
    logic [TW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane_of(input int v);
        logic [11:0] s;
        s = v[11:0];
        return {s, 4'b0000};
    endfunction

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic logic [TW-1:0] noise_word(input int base);
        logic [TW-1:0] w;
        for (int k = 0; k < TW / 16; k++) begin
            w[16*k +: 16] = lane_of(clamp((k % 2 == 0) ? base - 1 : base + 1));
        end
        return w;
    endfunction

    function automatic logic [TW-1:0] peak_word(input int h);
        logic [TW-1:0] w;
        for (int k = 0; k < TW / 16; k++) w[16*k +: 16] = lane_of(h);
        return w;
    endfunction

    task automatic apply_cfg(input tcfg_t c);
        baseline = ARW'(c.base);
        pre_len  = LW'(c.pre);
        fst_h    = ARW'(c.fh);
        fst_w    = LW'(c.fw);
        snd_h    = ARW'(c.sh);
        snd_w    = LW'(c.sw);
        gap_len  = LW'(c.gap);
        pcount   = LW'(c.cnt);
    endtask

    task automatic observe();
        logic [TW-1:0] e;
        cyc++;
        if (!capture) return;
        if (done) begin
            done_cnt++;
            check_eq("done_timing", TW'(cyc - last_beat_cyc), TW'(1));
            check_eq("done_queue_empty", TW'(exp_q.size()), '0);
            check_eq("busy_clear_at_done", TW'(busy), '0);
            check_eq("idle_noise_after_done", tdata, noise_word(base_now));
            capture = 1'b0;
            return;
        end
        if (tvalid && tready) begin
            last_beat_cyc = cyc;
            check_eq("beat_expected", TW'(exp_q.size() != 0), TW'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("beat_data", tdata, e);
            end
        end else if (tvalid && exp_q.size() != 0) begin
            check_eq("stall_hold", tdata, exp_q[0]);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_train(input tcfg_t c, input bit rnd, input int inject_at,
                             input int abort_at);
        int n;
        bit aborted;
        aborted = 1'b0;
        exp_q.delete();
        for (int p = 0; p < c.cnt; p++) begin
            n = (p == 0) ? c.pre : c.gap;
            for (int i = 0; i < n; i++) exp_q.push_back(noise_word(c.base));
            for (int i = 0; i < c.fw; i++) exp_q.push_back(peak_word(c.fh));
            for (int i = 0; i < c.sw; i++) exp_q.push_back(peak_word(c.sh));
        end
        apply_cfg(c);
        base_now = c.base;
        done_cnt = 0;
        start    = 1'b1;
        tready   = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_start", TW'(busy), TW'(1));
        capture       = 1'b1;
        last_beat_cyc = cyc;
        for (int i = 0; i < 5000 && capture; i++) begin
            if (abort_at > 0 && i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i == inject_at) begin
                // Ignored START plus live config edits while busy.
                start  = 1'b1;
                pcount = 16'd7;
                fst_h  = -12'sd100;
                fst_w  = 16'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start   = 1'b0;
        tready  = 1'b1;
        capture = 1'b0;
        if (aborted) begin
            exp_q.delete();
        end else begin
            check_eq("train_done_once", TW'(done_cnt), TW'(1));
            tick();
            check_eq("done_one_cycle", TW'(done), '0);
        end
    endtask

    tcfg_t cfg_a, cfg_b, cfg_z;

    initial begin
        cfg_a = '{base: 0, pre: 30, fh: 1637, fw: 50, sh: 204, sw: 38, gap: 100, cnt: 2};
        cfg_b = '{base: 2047, pre: 0, fh: 1637, fw: 5, sh: 204, sw: 3, gap: 10, cnt: 1};
        cfg_z = '{base: 0, pre: 4, fh: 500, fw: 4, sh: 300, sw: 4, gap: 4, cnt: 0};
        apply_cfg(cfg_z);

        // Reset and free-running start-up
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tvalid", TW'(tvalid), '0);
        check_eq("rst_tdata", tdata, '0);
        check_eq("rst_busy", TW'(busy), '0);
        check_eq("rst_done", TW'(done), '0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("tvalid_first_cycle", TW'(tvalid), '0);
        @(posedge clk);
        #1;
        check_eq("tvalid_after_release", TW'(tvalid), TW'(1));
        check_eq("idle_noise_b0", tdata, noise_word(0));
        check_eq("lane0_b0", TW'(tdata[15:0]), TW'(16'hFFF0));
        check_eq("lane1_b0", TW'(tdata[31:16]), TW'(16'h0010));
        check_eq("idle_busy", TW'(busy), '0);

        // Full train, always ready; then with random backpressure; then with an ignored START
        run_train(cfg_a, 1'b0, -1, 0);
        run_train(cfg_a, 1'b1, -1, 0);
        run_train(cfg_a, 1'b1, 20, 0);

        // Saturation at both ends of the range
        apply_cfg(cfg_b);
        repeat (2) tick();
        check_eq("idle_noise_sat_hi", tdata, noise_word(2047));
        check_eq("lane1_sat_hi", TW'(tdata[31:16]), TW'(16'h7FF0));
        baseline = -12'sd2048;
        repeat (2) tick();
        check_eq("lane0_sat_lo", TW'(tdata[15:0]), TW'(16'h8000));
        check_eq("idle_noise_sat_lo", tdata, noise_word(-2048));
        run_train(cfg_b, 1'b0, -1, 0);

        // Zero pulse count
        apply_cfg(cfg_z);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("zero_busy", TW'(busy), TW'(1));
        check_eq("zero_done_early", TW'(done), '0);
        tick();
        check_eq("zero_busy_clear", TW'(busy), '0);
        check_eq("zero_done", TW'(done), TW'(1));
        check_eq("zero_noise", tdata, noise_word(0));
        tick();
        check_eq("zero_done_one_cycle", TW'(done), '0);

        // Reset in the middle of the first peak
        run_train(cfg_a, 1'b0, -1, 40);
        rstn = 1'b0;
        #1;
        check_eq("abort_tvalid", TW'(tvalid), '0);
        check_eq("abort_busy", TW'(busy), '0);
        check_eq("abort_tdata", tdata, '0);
        repeat (2) tick();
        check_eq("abort_no_done", TW'(done), '0);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("abort_tvalid_release", TW'(tvalid), '0);
        @(posedge clk);
        #1;
        check_eq("abort_tvalid_back", TW'(tvalid), TW'(1));
        check_eq("abort_noise_back", tdata, noise_word(0));
        check_eq("abort_done_after", TW'(done), '0);
        run_train(cfg_a, 1'b0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_pulse_pattern_gen.md
Name: adc_pulse_pattern_gen

Overview:
- AXI-Stream master that synthesises RFSoC-ADC-format sample words for the trigger chain: alternating ±1 baseline noise plus programmable double-peak pulses.
- Drives the S_AXIS port of the trigger block in hardware self-test and loop-back builds, replacing the RF Data Converter stream.
- Pulse shape, spacing and count are latched on START. The block produces a finite pulse train, then returns to free-running noise.

Parameters:
- TDATA_WIDTH, 128: stream width; SAMPLE_PER_TDATA = TDATA_WIDTH/16 lanes.
- ADC_RESOLUTION_WIDTH, 12: signed sample width, MSB-aligned in each 16-bit lane.
- LEN_WIDTH, 16: width of all length/count configuration fields.

Ports:
- M_AXIS_ACLK  in  1  sole clock.
- M_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
- M_AXIS_TDATA  out  TDATA_WIDTH  packed samples; lane k = TDATA[16k+15:16k] = {sample, 4'b0}.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TREADY  in  1  stream ready.
- START  in  1  one-cycle pulse; arms a pulse train.
- BASELINE  in  ADC_RESOLUTION_WIDTH  signed noise centre.
- PRE_LEN  in  LEN_WIDTH  noise words before the first pulse.
- FST_HEIGHT  in  ADC_RESOLUTION_WIDTH  signed first-peak sample value.
- FST_WIDTH  in  LEN_WIDTH  first-peak length in words.
- SND_HEIGHT  in  ADC_RESOLUTION_WIDTH  signed second-peak sample value.
- SND_WIDTH  in  LEN_WIDTH  second-peak length in words.
- GAP_LEN  in  LEN_WIDTH  noise words between pulses.
- PULSE_COUNT  in  LEN_WIDTH  number of double-peak pulses.
- BUSY  out  1  high while a pulse train is in progress.
- DONE  out  1  one-cycle pulse when the train completes.

Behaviour:
- Reset values:
  - TVALID = 0, TDATA = 0, BUSY = 0, DONE = 0.
  - State = IDLE; all counters = 0.
  - Asserting reset mid-train aborts the train immediately; no DONE is produced.
- First cycle after reset release: TVALID goes to 1 and stays 1 until the next reset (free-running ADC model).
- Transfer rule:
  - A "beat" is a cycle with TVALID & TREADY.
  - Counters and state advance only on beats.
  - TDATA is held stable while TVALID & ~TREADY.
- Noise word:
  - Even lanes = BASELINE-1, odd lanes = BASELINE+1.
  - Each value is computed at ADC_RESOLUTION_WIDTH+1 bits and saturated to [-2^(N-1), 2^(N-1)-1].
- Peak word: all lanes = FST_HEIGHT (or SND_HEIGHT), no noise added.
- Configuration: latched on START only in IDLE. START while BUSY is ignored. Live config changes during a train have no effect.
- FSM states: IDLE, PRE, FST, SND, GAP.
  - IDLE: emits noise. On START, latch config and set BUSY = 1.
    - If PULSE_COUNT = 0: stay in IDLE and pulse DONE next cycle.
    - Otherwise go to PRE.
  - PRE: emits noise for PRE_LEN beats, then goes to FST.
  - FST: emits FST_HEIGHT for FST_WIDTH beats, then goes to SND.
  - SND: emits SND_HEIGHT for SND_WIDTH beats.
    - Then decrement the remaining-pulse counter.
    - If remaining > 0, go to GAP; else go to IDLE, BUSY = 0, DONE = 1 for one cycle.
  - GAP: emits noise for GAP_LEN beats, then goes to FST.
- Any zero-length state is skipped in the same transition, emitting no beats: PRE_LEN=0 goes straight to FST; FST_WIDTH=0 and SND_WIDTH=0 give a pulse with zero words.
- Output register: TDATA is registered. The word for the new state is presented on the cycle after the beat that completed the previous state, so there are no bubbles and no duplicated words.
- Counters: LEN_WIDTH bits, down-counting from the latched value. Max length 2^LEN_WIDTH-1 with no wrap; the counter stops at 1 → transition.

Decomposition:
- Shared package: lane packing function (sample → {sample, 4'b0}), saturating add helper, and FSM state enum. All trigger-chain stimulus and capture blocks use the same lane layout.
- One sub-module is natural: adc_word_packer, a combinational replicate/saturate/pack of one sample pair into TDATA.
- The FSM and counters stay in the top module.

Test Plan:
- Reset with TREADY=1 → TVALID=0 during reset, 1 one cycle after release. TDATA lanes alternate 0xFFF0/0x0010 for BASELINE=0, BUSY=0.
- BASELINE=0, PRE_LEN=30, FST_HEIGHT=1637, FST_WIDTH=50, SND_HEIGHT=204, SND_WIDTH=38, GAP_LEN=100, PULSE_COUNT=2, START → exactly 30 noise, 50×0x6650, 38×0x0CC0, 100 noise, 50×0x6650, 38×0x0CC0 beats. DONE pulses once on the cycle after the final SND beat.
- Same config with TREADY toggling pseudo-randomly (50%) → identical beat sequence; TDATA stable during every stall.
- BASELINE=2047, PULSE_COUNT=1, PRE_LEN=0 → noise odd lanes saturate to 0x7FF0. First beat after START is FST data.
- PULSE_COUNT=0 START → BUSY high for one cycle, DONE next cycle, output stays noise. START during BUSY → ignored; total pulse count unchanged.
- Reset asserted mid-FST → TVALID=0 asynchronously, BUSY=0, no DONE. After release, noise resumes and a new START runs a full train.
